// File: rtl/octal_key_capture_pkg.sv
// Shared types and helpers for the octal key capture front end.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package octal_key_pkg;

  localparam int NUM_KEYS = 8;

  typedef logic [NUM_KEYS-1:0] key_vec_t;

  typedef enum logic {
    IDLE = 1'b0,
    OUT  = 1'b1
  } state_t;

  // Isolate the lowest set bit (two's complement trick).
  function automatic key_vec_t pick_low(input key_vec_t v);
    key_vec_t w_neg;
    w_neg = ~v + key_vec_t'(1);
    return v & w_neg;
  endfunction

  // Isolate the highest set bit; later (higher) hits overwrite earlier ones.
  function automatic key_vec_t pick_high(input key_vec_t v);
    key_vec_t r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // True when two or more bits are set.
  function automatic logic multi_hot(input key_vec_t v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) cnt++;
    end
    return (cnt > 1);
  endfunction

endpackage

// File: rtl/octal_key_capture_if.sv
// Output handshake bundle: one-hot press code with valid/ready.
// Latency: n/a (wiring only).
// Backpressure: slave holds ready low to stall; master holds code and valid.
interface octal_key_capture_if;
  import octal_key_pkg::*;

  key_vec_t onehot_out;
  logic     valid;
  logic     ready;

  modport master (output onehot_out, output valid, input ready);
  modport slave  (input onehot_out, input valid, output ready);

endinterface

// File: rtl/octal_key_capture_debounce.sv
// One key line: 2-flop synchronizer followed by a saturating-free debounce counter.
// Latency: stable follows a new raw level DEBOUNCE_CYCLES+2 edges after it is first sampled.
// Backpressure: none; free-running per line.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_stable
);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  // Synchronize the raw line, then flip stable only after a sustained difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_key;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/octal_key_capture.sv
// Debounces 8 key lines, queues rising edges as pending, emits them one-hot one at a time.
// Latency: valid rises DEBOUNCE_CYCLES+4 edges after a new level is first sampled; 1 idle cycle between codes.
// Backpressure: code and valid held while ready=0; new presses accumulate in pending.
// Build option: define OCTAL_KEY_PRIO_HIGH_EN to serve the highest-index pending key first.
module octal_key_capture
  import octal_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  key_vec_t                   key_in,
  input  logic                       err_clr,
  octal_key_capture_if.master        out_if,
  output logic                       multi_err
);

  key_vec_t w_stable;
  key_vec_t w_rise;
  key_vec_t w_pick;
  key_vec_t w_clr;
  key_vec_t w_onehot_nxt;
  logic     w_valid_nxt;
  state_t   w_state_nxt;

  key_vec_t r_stable_d;
  key_vec_t r_pending;
  key_vec_t r_onehot;
  logic     r_valid;
  logic     r_multi_err;
  state_t   r_state;

  genvar g;
  generate
    for (g = 0; g < NUM_KEYS; g++) begin : g_db
      key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_db (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_key    (key_in[g]),
        .o_stable (w_stable[g])
      );
    end
  endgenerate

  assign w_rise = w_stable & ~r_stable_d;

`ifdef OCTAL_KEY_PRIO_HIGH_EN
  assign w_pick = pick_high(r_pending);
`else
  assign w_pick = pick_low(r_pending);
`endif

  // Next-state and next-output decode for the present/handshake FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_onehot_nxt = r_onehot;
    w_valid_nxt  = r_valid;
    w_clr        = '0;
    case (r_state)
      IDLE: begin
        if (r_pending != '0) begin
          w_onehot_nxt = w_pick;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = OUT;
        end
      end
      OUT: begin
        if (out_if.ready) begin
          w_clr        = r_onehot;
          w_onehot_nxt = '0;
          w_valid_nxt  = 1'b0;
          w_state_nxt  = IDLE;
        end
      end
      default: begin
        w_onehot_nxt = '0;
        w_valid_nxt  = 1'b0;
        w_state_nxt  = IDLE;
      end
    endcase
  end

  // FSM state, output registers, pending set (a fresh rise beats a same-cycle clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_onehot   <= '0;
      r_valid    <= 1'b0;
      r_pending  <= '0;
      r_stable_d <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_onehot   <= w_onehot_nxt;
      r_valid    <= w_valid_nxt;
      r_pending  <= (r_pending & ~w_clr) | w_rise;
      r_stable_d <= w_stable;
    end
  end

  // Sticky multi-key flag; a live multi-hot condition overrides the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_multi_err <= 1'b0;
    end else if (multi_hot(w_stable)) begin
      r_multi_err <= 1'b1;
    end else if (err_clr) begin
      r_multi_err <= 1'b0;
    end
  end

  assign out_if.onehot_out = r_onehot;
  assign out_if.valid      = r_valid;
  assign multi_err         = r_multi_err;

endmodule

// File: doc/octal_key_capture.md
Name: octal_key_capture

Overview:
- Upstream front end for the octal-to-binary encoder.
- Synchronizes and debounces 8 raw key/switch lines, detects presses (rising edges) and queues them as pending.
- Presents each pending press, one at a time, as a clean one-hot 8-bit code with a valid/ready handshake.
- The downstream encoder therefore only ever sees one-hot or all-zero input, never a glitch or a multi-hot pattern.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized line must differ from its stable value before the stable value flips. Legal range 2..255.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- key_in  input  8  raw asynchronous key lines, active-high.
- err_clr  input  1  clears the sticky multi_err flag.
- ready  input  1  downstream accepts the current code.
- onehot_out  output  8  one-hot press code; 8'h00 when valid=0.
- valid  output  1  onehot_out holds a press.
- multi_err  output  1  sticky: more than one debounced line was high at once.

Behaviour:
- Reset (rst_n=0) is asynchronous and active-low. All of the following clear immediately, including mid-handshake:
  - sync flops, stable, stable_d, counters and pending all go to 0;
  - onehot_out=8'h00, valid=0, multi_err=0;
  - FSM goes to IDLE.
- Synchronizer: two flops per line (s1, s2).
- Debounce, per line:
  - If s2==stable, counter<=0.
  - Otherwise counter increments.
  - At the edge where counter==DEBOUNCE_CYCLES-1, stable<=s2 and counter<=0.
- Press detect: rise = stable & ~stable_d (stable_d is stable delayed by one cycle); pending <= pending | rise.
- Release detect: releases (falling edges) are not reported.
- Latency, counting edge 1 as the first edge sampling a new stable high level, with the FSM in IDLE:
  - stable flips at edge DEBOUNCE_CYCLES+2;
  - pending sets at edge +3;
  - valid rises at edge DEBOUNCE_CYCLES+4 (edge 8 for the default).
- Glitch rejection: a level held for fewer than DEBOUNCE_CYCLES cycles at s2 produces no press.
- FSM states: IDLE, OUT.
  - IDLE, pending!=0: select the lowest-index pending bit, load onehot_out with that bit, valid<=1, go to OUT.
  - IDLE, pending==0: outputs stay 0.
  - OUT: onehot_out and valid are held stable until ready=1.
  - OUT, ready=1: clear the selected pending bit, onehot_out<=0, valid<=0, go to IDLE.
  - The mandatory IDLE bubble means a maximum throughput of one code per 2 cycles.
- Simultaneous set and clear: if rise and handshake-clear hit the same pending bit in the same cycle, set wins (the new press is retained).
- Presses arriving during OUT accumulate in pending. A repeat press of an already-pending key merges (no counting).
- multi_err:
  - Set when popcount(stable)>1.
  - Cleared by err_clr=1.
  - If set and err_clr occur in the same cycle, set wins.
  - Error detection does not block capture.
- valid never deasserts without ready, except under reset.

Optional Feature:
- Macro: OCTAL_KEY_PRIO_HIGH_EN.
- Defined: the IDLE selection picks the highest-index pending bit.
- Undefined (default): the IDLE selection picks the lowest-index pending bit.
- All other behaviour is identical.

Decomposition:
- Package octal_key_pkg:
  - NUM_KEYS=8;
  - typedef key_vec_t (logic [NUM_KEYS-1:0]);
  - enum state_t {IDLE, OUT}.
- Sub-module key_debounce (one line: synchronizer, counter, stable), parameterized by DEBOUNCE_CYCLES.
  - Instantiated NUM_KEYS times via generate.
  - Priority select, pending register, FSM and multi_err live in the top module.

Test Plan:
- Reset, then key_in=8'h04 held, ready=1:
  - valid rises at edge 8 with onehot_out=8'h04;
  - valid drops the next cycle;
  - no further valid while the key stays held.
- key_in bit0 pulses high for 3 cycles (DEBOUNCE_CYCLES=4): no valid, pending stays 0, multi_err=0.
- key_in=8'h81 rising together, ready=1:
  - codes 8'h01 then 8'h80, valid high on alternating cycles;
  - multi_err=1;
  - with OCTAL_KEY_PRIO_HIGH_EN, the order is 8'h80 then 8'h01.
- ready=0, press key 2:
  - valid=1, onehot_out=8'h04 held stable for 20 cycles;
  - press key 5 meanwhile;
  - raise ready: 8'h04 accepted, then 8'h20 presented two cycles later.
- rst_n pulsed low mid-OUT: valid, onehot_out, pending and multi_err go to 0 immediately (asynchronously). After release, no stale code appears.
- multi_err=1, assert err_clr while two keys are still stable-high: flag stays 1. Release the keys, assert err_clr: flag goes to 0.
